// File: rtl/prim_count_chk_pkg.sv
// Shared types for the lockstep counter checker: sparse FSM encoding, sticky cause bits
// and the mapping from the sparse state to its 2-bit debug view.
package prim_count_chk_pkg;

  // Pairwise Hamming distance >= 3 so a single upset never lands on another legal state.
  typedef enum logic [5:0] {
    StIdle  = 6'b000111,
    StSync  = 6'b011000,
    StTrack = 6'b101010,
    StErr   = 6'b110101
  } state_e;

  typedef struct packed {
    logic next_mismatch;
    logic cnt_err;
    logic mismatch;
  } err_code_t;

  function automatic logic [1:0] state_to_dbg(state_e st);
    case (st)
      StIdle:  return 2'd0;
      StSync:  return 2'd1;
      StTrack: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/prim_count_chk_model.sv
// Combinational next-value calculator that mirrors the protected counter, including its
// saturation at all-ones on increment overflow and at zero on decrement underflow.
module prim_count_chk_model #(
  parameter int unsigned       Width      = 4,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic [Width-1:0] cur,
  input  logic             clr,
  input  logic             set,
  input  logic [Width-1:0] set_cnt,
  input  logic             incr_en,
  input  logic             decr_en,
  input  logic [Width-1:0] step,
  output logic [Width-1:0] nxt
);

  logic [Width:0] sum;
  logic [Width:0] diff;

  // The extra top bit carries the overflow / borrow that drives saturation.
  assign sum  = {1'b0, cur} + {1'b0, step};
  assign diff = {1'b0, cur} - {1'b0, step};

  always_comb begin
    nxt = cur;
    if (clr) begin
      nxt = ResetValue;
    end else if (set) begin
      nxt = set_cnt;
    end else if (incr_en && !decr_en) begin
      nxt = sum[Width] ? '1 : sum[Width-1:0];
    end else if (decr_en && !incr_en) begin
      nxt = diff[Width] ? '0 : diff[Width-1:0];
    end
  end

endmodule

// File: rtl/prim_count_chk.sv
// Lockstep checker for a hardened cross counter; raises a sticky fatal on divergence.
// Optional feature macro: PRIM_COUNT_CHK_NEXT_EN (also checks the counter's next-value output).
module prim_count_chk
  import prim_count_chk_pkg::*;
#(
  parameter int unsigned       Width      = 4,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             chk_en_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             incr_en_i,
  input  logic             decr_en_i,
  input  logic [Width-1:0] step_i,
  input  logic [Width-1:0] cnt_i,
  input  logic [Width-1:0] cnt_next_i,
  input  logic             cnt_err_i,
  output logic             mismatch_o,
  output logic             err_o,
  output logic [2:0]       err_code_o,
  output logic [1:0]       state_o
);

  state_e           state_q;
  logic [Width-1:0] exp_q;
  logic [Width-1:0] model_nxt;
  logic [Width-1:0] sync_nxt;
  logic             mismatch_q;
  logic             err_q;
  err_code_t        code_q;
  logic             cnt_mis;
  logic             next_mis;

  // Model path advances the checker's own count; resync path adopts the counter's value.
  prim_count_chk_model #(.Width(Width), .ResetValue(ResetValue)) u_model (
    .cur     (exp_q),
    .clr     (clr_i),
    .set     (set_i),
    .set_cnt (set_cnt_i),
    .incr_en (incr_en_i),
    .decr_en (decr_en_i),
    .step    (step_i),
    .nxt     (model_nxt)
  );

  prim_count_chk_model #(.Width(Width), .ResetValue(ResetValue)) u_sync (
    .cur     (cnt_i),
    .clr     (clr_i),
    .set     (set_i),
    .set_cnt (set_cnt_i),
    .incr_en (incr_en_i),
    .decr_en (decr_en_i),
    .step    (step_i),
    .nxt     (sync_nxt)
  );

  assign cnt_mis = (cnt_i != exp_q);

`ifdef PRIM_COUNT_CHK_NEXT_EN
  assign next_mis   = (cnt_next_i != model_nxt);
  assign err_code_o = code_q;
`else
  logic unused_next;
  assign unused_next = ^{cnt_next_i, code_q.next_mismatch};
  assign next_mis    = 1'b0;
  assign err_code_o  = {1'b0, code_q.cnt_err, code_q.mismatch};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      exp_q      <= ResetValue;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        StIdle: begin
          exp_q <= sync_nxt;
          if (chk_en_i) state_q <= StSync;
        end
        StSync: begin
          exp_q   <= sync_nxt;
          state_q <= chk_en_i ? StTrack : StIdle;
        end
        StTrack: begin
          exp_q <= model_nxt;
          if (!chk_en_i) begin
            state_q <= StIdle;
          end else if (cnt_mis || cnt_err_i || next_mis) begin
            state_q    <= StErr;
            err_q      <= 1'b1;
            mismatch_q <= cnt_mis | next_mis;
            code_q     <= '{next_mismatch: next_mis, cnt_err: cnt_err_i, mismatch: cnt_mis};
          end
        end
        StErr: begin
        end
        // A corrupted state register is itself a fatal condition.
        default: begin
          state_q <= StErr;
          err_q   <= 1'b1;
          code_q  <= '1;
        end
      endcase
    end
  end

  assign mismatch_o = mismatch_q;
  assign err_o      = err_q;
  assign state_o    = state_to_dbg(state_q);

endmodule

// File: tb/tb_prim_count_chk.sv
// Self-checking bench for prim_count_chk (Width=4, ResetValue=0); directed scenarios plus a
// randomized run against a behavioural checker model. PRIM_COUNT_CHK_NEXT_EN adds the next-value test.
module tb_prim_count_chk;

  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_i, chk_en_i, clr_i, set_i, incr_en_i, decr_en_i, cnt_err_i;
  logic [W-1:0] set_cnt_i, step_i, cnt_i, cnt_next_i;
  logic         mismatch_o, err_o;
  logic [2:0]   err_code_o;
  logic [1:0]   state_o;

  int total = 0;
  int bad   = 0;

  logic [1:0] r_state;
  int         r_exp;
  logic       r_err;
  logic [2:0] r_code;
  logic       r_mis;
  bit         hold_next = 1'b0;

  prim_count_chk #(.Width(W), .ResetValue('0)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .chk_en_i   (chk_en_i),
    .clr_i      (clr_i),
    .set_i      (set_i),
    .set_cnt_i  (set_cnt_i),
    .incr_en_i  (incr_en_i),
    .decr_en_i  (decr_en_i),
    .step_i     (step_i),
    .cnt_i      (cnt_i),
    .cnt_next_i (cnt_next_i),
    .cnt_err_i  (cnt_err_i),
    .mismatch_o (mismatch_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Counter semantics from the rules: clr > set > single-direction count, saturating at 0..15.
  function automatic int f_next(int cur);
    int s;
    s = int'(step_i);
    if (clr_i) return 0;
    if (set_i) return int'(set_cnt_i);
    if (incr_en_i && !decr_en_i) return (cur + s > 15) ? 15 : cur + s;
    if (decr_en_i && !incr_en_i) return (cur < s) ? 0 : cur - s;
    return cur;
  endfunction

  // Expected checker behaviour for the cycle whose inputs are currently applied.
  task automatic ref_cycle();
    bit cm, ce, nm;
    int nv;
    r_mis = 1'b0;
    if (rst_i) begin
      r_state = 2'd0; r_exp = 0; r_err = 1'b0; r_code = 3'b000;
      return;
    end
    case (r_state)
      2'd0: begin
        r_exp = f_next(int'(cnt_i));
        if (chk_en_i) r_state = 2'd1;
      end
      2'd1: begin
        r_exp   = f_next(int'(cnt_i));
        r_state = chk_en_i ? 2'd2 : 2'd0;
      end
      2'd2: begin
        nv = f_next(r_exp);
        if (!chk_en_i) begin
          r_state = 2'd0;
        end else begin
          cm = (int'(cnt_i) != r_exp);
          ce = cnt_err_i;
          nm = 1'b0;
`ifdef PRIM_COUNT_CHK_NEXT_EN
          nm = (int'(cnt_next_i) != nv);
`endif
          if (cm || ce || nm) begin
            r_state = 2'd3; r_err = 1'b1; r_code = {nm, ce, cm}; r_mis = cm | nm;
          end
        end
        r_exp = nv;
      end
      default: begin
      end
    endcase
  endtask

  // Advances one clock: a well-behaved counter follows the applied command.
  task automatic tick();
    int c_next, nv;
    nv = f_next(int'(cnt_i));
    if (!hold_next) cnt_next_i = nv[W-1:0];
    c_next = rst_i ? 0 : nv;
    ref_cycle();
    @(posedge clk_i);
    #1;
    cnt_i = c_next[W-1:0];
  endtask

  task automatic idle_cmd();
    clr_i = 1'b0; set_i = 1'b0; set_cnt_i = '0; incr_en_i = 1'b0; decr_en_i = 1'b0;
    step_i = '0; cnt_err_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_cmd();
    rst_i = 1'b1; chk_en_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic enter_track();
    chk_en_i = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    cnt_i = '0; cnt_next_i = '0;
    do_reset();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== 7'b0) begin
      bad++; $display("[TB] FAIL reset_outputs: got %b expected %b", {err_o, err_code_o, mismatch_o, state_o}, 7'b0);
    end
    tick();
    total++;
    if (state_o !== 2'd0 || err_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_idle: state %0d err %b expected state 0 err 0", state_o, err_o);
    end
  endtask

  task automatic test_incr_sat();
    chk_en_i = 1'b1;
    tick();
    total++;
    if (state_o !== 2'd1) begin
      bad++; $display("[TB] FAIL enter_sync: state %0d expected 1", state_o);
    end
    tick();
    total++;
    if (state_o !== 2'd2) begin
      bad++; $display("[TB] FAIL enter_track: state %0d expected 2", state_o);
    end
    incr_en_i = 1'b1; step_i = 4'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b0, 3'b000, 1'b0, 2'd2}) begin
        bad++; $display("[TB] FAIL incr_step%0d: got %b expected 0000010", i, {err_o, err_code_o, mismatch_o, state_o});
      end
    end
    idle_cmd();
    tick();
    total++;
    if (err_o !== 1'b0 || state_o !== 2'd2) begin
      bad++; $display("[TB] FAIL sat_hold: err %b state %0d expected err 0 state 2", err_o, state_o);
    end
  endtask

  task automatic test_mismatch();
    set_i = 1'b1; set_cnt_i = 4'd6;
    tick();
    idle_cmd();
    cnt_i = 4'd7;
    tick();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b1, 3'b001, 1'b1, 2'd3}) begin
      bad++; $display("[TB] FAIL mismatch_detect: got %b expected 1001111", {err_o, err_code_o, mismatch_o, state_o});
    end
    chk_en_i = 1'b0; incr_en_i = 1'b1; step_i = 4'd2;
    tick();
    tick();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b1, 3'b001, 1'b0, 2'd3}) begin
      bad++; $display("[TB] FAIL mismatch_sticky: got %b expected 1001011", {err_o, err_code_o, mismatch_o, state_o});
    end
    do_reset();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== 7'b0) begin
      bad++; $display("[TB] FAIL err_reset: got %b expected 0000000", {err_o, err_code_o, mismatch_o, state_o});
    end
  endtask

  task automatic test_cnt_err();
    enter_track();
    cnt_err_i = 1'b1;
    tick();
    cnt_err_i = 1'b0;
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b1, 3'b010, 1'b0, 2'd3}) begin
      bad++; $display("[TB] FAIL cnt_err_detect: got %b expected 1010011", {err_o, err_code_o, mismatch_o, state_o});
    end
    tick();
    total++;
    if (err_o !== 1'b1 || state_o !== 2'd3 || err_code_o !== 3'b010) begin
      bad++; $display("[TB] FAIL cnt_err_sticky: err %b code %b state %0d expected 1 010 3", err_o, err_code_o, state_o);
    end
  endtask

  task automatic test_priority();
    do_reset();
    enter_track();
    incr_en_i = 1'b1; step_i = 4'd5;
    tick();
    clr_i = 1'b1; set_i = 1'b1; set_cnt_i = 4'd9; incr_en_i = 1'b1; step_i = 4'd3;
    tick();
    idle_cmd();
    tick();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b0, 3'b000, 1'b0, 2'd2}) begin
      bad++; $display("[TB] FAIL clr_priority: got %b expected 0000010", {err_o, err_code_o, mismatch_o, state_o});
    end
    incr_en_i = 1'b1; decr_en_i = 1'b1; step_i = 4'd7;
    tick();
    idle_cmd();
    decr_en_i = 1'b1; step_i = 4'd1;
    tick();
    idle_cmd();
    tick();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b0, 3'b000, 1'b0, 2'd2}) begin
      bad++; $display("[TB] FAIL hold_and_underflow: got %b expected 0000010", {err_o, err_code_o, mismatch_o, state_o});
    end
  endtask

  task automatic test_resync();
    chk_en_i = 1'b0;
    tick();
    total++;
    if (state_o !== 2'd0) begin
      bad++; $display("[TB] FAIL disable_idle: state %0d expected 0", state_o);
    end
    cnt_i = 4'd3;
    tick();
    cnt_i = 4'd12; cnt_err_i = 1'b1;
    tick();
    cnt_err_i = 1'b0;
    total++;
    if (err_o !== 1'b0 || state_o !== 2'd0) begin
      bad++; $display("[TB] FAIL idle_ignores: err %b state %0d expected 0 0", err_o, state_o);
    end
    chk_en_i = 1'b1;
    tick();
    cnt_err_i = 1'b1;
    tick();
    cnt_err_i = 1'b0;
    total++;
    if (state_o !== 2'd2 || err_o !== 1'b0) begin
      bad++; $display("[TB] FAIL sync_to_track: state %0d err %b expected 2 0", state_o, err_o);
    end
    incr_en_i = 1'b1; step_i = 4'd1;
    tick();
    tick();
    idle_cmd();
    tick();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b0, 3'b000, 1'b0, 2'd2}) begin
      bad++; $display("[TB] FAIL resync_clean: got %b expected 0000010", {err_o, err_code_o, mismatch_o, state_o});
    end
  endtask

`ifdef PRIM_COUNT_CHK_NEXT_EN
  task automatic test_next();
    do_reset();
    enter_track();
    incr_en_i = 1'b1; step_i = 4'd5;
    hold_next = 1'b1; cnt_next_i = 4'd4;
    tick();
    hold_next = 1'b0;
    idle_cmd();
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== {1'b1, 3'b100, 1'b1, 2'd3}) begin
      bad++; $display("[TB] FAIL next_mismatch: got %b expected 1100111", {err_o, err_code_o, mismatch_o, state_o});
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++;
    if ({err_o, err_code_o, mismatch_o, state_o} !== 7'b0) begin
      bad++; $display("[TB] FAIL next_reset: got %b expected 0000000", {err_o, err_code_o, mismatch_o, state_o});
    end
  endtask
`endif

  task automatic test_random();
    int err_cycles;
    do_reset();
    chk_en_i = 1'b1;
    err_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      clr_i     = ($urandom_range(15) == 0);
      set_i     = ($urandom_range(7) == 0);
      set_cnt_i = 4'($urandom_range(15));
      incr_en_i = 1'($urandom_range(1));
      decr_en_i = 1'($urandom_range(1));
      step_i    = 4'($urandom_range(15));
      cnt_err_i = ($urandom_range(69) == 0);
      if (chk_en_i) chk_en_i = ($urandom_range(29) != 0);
      else          chk_en_i = ($urandom_range(3) == 0);
      if ($urandom_range(49) == 0) cnt_i = cnt_i ^ 4'($urandom_range(15, 1));
      rst_i = (err_cycles >= 3);
      if (rst_i) err_cycles = 0;
      tick();
      if (r_state == 2'd3) err_cycles++;
      total++;
      if ({err_o, err_code_o, mismatch_o, state_o} !== {r_err, r_code, r_mis, r_state}) begin
        bad++;
        $display("[TB] FAIL random_cycle%0d: got %b expected %b", i,
                 {err_o, err_code_o, mismatch_o, state_o}, {r_err, r_code, r_mis, r_state});
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; chk_en_i = 1'b0;
    idle_cmd();
    test_reset();
    test_incr_sat();
    test_mismatch();
    test_cnt_err();
    test_priority();
    test_resync();
`ifdef PRIM_COUNT_CHK_NEXT_EN
    test_next();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
